// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with stall hold buffer, branch redirect and halt
module if_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [7:0]  branch_target,
    output logic [7:0]  imem_addr,
    input  logic [15:0] imem_data,
    output logic [7:0]  odata_read_addr,
    output logic [7:0]  odata_write_addr,
    output logic [7:0]  onextPC,
    output logic        ifid_en,
    output logic        halted
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state, state_n;
    logic [7:0]  pc, pc_n;
    logic [7:0]  fetch_pc, fetch_pc_n;
    logic        fetch_valid, fetch_valid_n;
    logic        held, held_n;
    logic [15:0] hold_word, hold_word_n;
    logic [7:0]  hold_next, hold_next_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= 8'h00;
            fetch_pc    <= 8'h00;
            fetch_valid <= 1'b0;
            held        <= 1'b0;
            hold_word   <= 16'h0000;
            hold_next   <= 8'h00;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            fetch_pc    <= fetch_pc_n;
            fetch_valid <= fetch_valid_n;
            held        <= held_n;
            hold_word   <= hold_word_n;
            hold_next   <= hold_next_n;
        end
    end

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        fetch_pc_n    = fetch_pc;
        fetch_valid_n = fetch_valid;
        held_n        = held;
        hold_word_n   = hold_word;
        hold_next_n   = hold_next;
        ifid_en       = 1'b0;
        if (state == RUN) begin
            if (branch_taken) begin
                pc_n          = branch_target;
                fetch_valid_n = 1'b0;
                held_n        = 1'b0;
                if (branch_target == 8'hFF)
                    state_n = HALT;
            end else if (stall) begin
                // The ROM keeps reading pc during a stall, so the live word must be parked.
                if (fetch_valid && !held) begin
                    held_n      = 1'b1;
                    hold_word_n = imem_data;
                    hold_next_n = fetch_pc + 8'd1;
                end
            end else begin
                ifid_en       = fetch_valid | held;
                pc_n          = pc + 8'd1;
                fetch_pc_n    = pc;
                fetch_valid_n = 1'b1;
                held_n        = 1'b0;
            end
        end
    end

    always_comb begin
        odata_read_addr  = 8'h00;
        odata_write_addr = 8'h00;
        onextPC          = 8'h00;
        if (held) begin
            odata_read_addr  = hold_word[15:8];
            odata_write_addr = hold_word[7:0];
            onextPC          = hold_next;
        end else if (fetch_valid) begin
            odata_read_addr  = imem_data[15:8];
            odata_write_addr = imem_data[7:0];
            onextPC          = fetch_pc + 8'd1;
        end
    end

    assign imem_addr = pc;
    assign halted    = (state == HALT);

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [7:0]  odata_read_addr;
    logic [7:0]  odata_write_addr;
    logic [7:0]  onextPC;
    logic        ifid_en;
    logic        halted;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    if_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .imem_addr        (imem_addr),
        .imem_data        (imem_data),
        .odata_read_addr  (odata_read_addr),
        .odata_write_addr (odata_write_addr),
        .onextPC          (onextPC),
        .ifid_en          (ifid_en),
        .halted           (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM with ROM[n] = {n, ~n}
    always @(posedge clk) imem_data <= {imem_addr, ~imem_addr};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_instr(input string tag, input logic [7:0] n);
        logic [7:0] nx;
        logic [7:0] nn;
        nx = n + 8'd1;
        nn = ~n;
        check_val({tag, ".en"}, 32'(ifid_en), 32'd1);
        check_val({tag, ".rd"}, 32'(odata_read_addr), 32'(n));
        check_val({tag, ".wr"}, 32'(odata_write_addr), 32'(nn));
        check_val({tag, ".np"}, 32'(onextPC), 32'(nx));
    endtask

    task automatic expect_idle(input string tag);
        check_val({tag, ".en"}, 32'(ifid_en), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 8'h00;

        repeat (3) @(negedge clk);
        #1;
        expect_idle("rst");
        check_val("rst.halted", 32'(halted), 32'd0);
        check_val("rst.rd", 32'(odata_read_addr), 32'd0);
        check_val("rst.wr", 32'(odata_write_addr), 32'd0);
        check_val("rst.np", 32'(onextPC), 32'd0);
        check_val("rst.addr", 32'(imem_addr), 32'd0);

        @(negedge clk); rst_n = 1'b1; #1;
        expect_idle("post_rst");
        check_val("post_rst.rd", 32'(odata_read_addr), 32'd0);

        for (int n = 0; n < 5; n++) begin
            @(negedge clk); #1;
            expect_instr("run", 8'(n));
        end

        // Stall three cycles while instruction 5 is presented
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); stall = 1'b1; #1;
            expect_idle("stall");
            check_val("stall.rd", 32'(odata_read_addr), 32'd5);
        end
        @(negedge clk); stall = 1'b0; #1;
        expect_instr("rel5", 8'd5);
        @(negedge clk); #1; expect_instr("rel6", 8'd6);
        @(negedge clk); #1; expect_instr("rel7", 8'd7);
        @(negedge clk); #1; expect_instr("pre_br8", 8'd8);

        // Redirect to 0x40 while instruction 9 is on the fetch bus
        @(negedge clk); branch_taken = 1'b1; branch_target = 8'h40; #1;
        expect_idle("br40");
        @(negedge clk); branch_taken = 1'b0; #1;
        expect_idle("br40_bubble");
        check_val("br40.addr", 32'(imem_addr), 32'h40);
        @(negedge clk); #1; expect_instr("br40_t", 8'h40);
        @(negedge clk); #1; expect_instr("br40_t1", 8'h41);

        // Branch and stall together: redirect wins
        @(negedge clk); branch_taken = 1'b1; stall = 1'b1; branch_target = 8'h10; #1;
        expect_idle("brst");
        @(negedge clk); branch_taken = 1'b0; stall = 1'b0; #1;
        check_val("brst.addr", 32'(imem_addr), 32'h10);
        expect_idle("brst_bubble");
        @(negedge clk); #1; expect_instr("brst_t", 8'h10);

        // Sequential wrap through 0xFF
        @(negedge clk); branch_taken = 1'b1; branch_target = 8'hFC; #1;
        expect_idle("brfc");
        @(negedge clk); branch_taken = 1'b0; #1;
        expect_idle("brfc_bubble");
        for (int n = 8'hFC; n <= 8'hFF; n++) begin
            @(negedge clk); #1;
            expect_instr("wrap", 8'(n));
        end
        @(negedge clk); #1;
        expect_instr("wrap00", 8'h00);
        check_val("wrap.halted", 32'(halted), 32'd0);

        // Halt on branch to 0xFF; stall and branch are then ignored
        @(negedge clk); branch_taken = 1'b1; branch_target = 8'hFF; #1;
        expect_idle("brff");
        @(negedge clk); branch_taken = 1'b0; #1;
        check_val("halt.halted", 32'(halted), 32'd1);
        expect_idle("halt");
        @(negedge clk); stall = 1'b1; #1;
        @(negedge clk); stall = 1'b0; branch_taken = 1'b1; branch_target = 8'h20; #1;
        expect_idle("halt_br");
        @(negedge clk); branch_taken = 1'b0; #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check_val("halt.hold", 32'(halted), 32'd1);
            check_val("halt.addr", 32'(imem_addr), 32'hFF);
            expect_idle("halt_idle");
        end

        @(negedge clk); rst_n = 1'b0; #1;
        @(negedge clk); rst_n = 1'b1; #1;
        check_val("unhalt.halted", 32'(halted), 32'd0);
        check_val("unhalt.addr", 32'(imem_addr), 32'h00);
        expect_idle("unhalt");
        @(negedge clk); #1; expect_instr("unhalt0", 8'h00);
        @(negedge clk); #1; expect_instr("unhalt1", 8'h01);

        // Reset in the middle of a stall with a word parked
        @(negedge clk); stall = 1'b1; #1;
        expect_idle("mstall");
        check_val("mstall.rd", 32'(odata_read_addr), 32'd2);
        @(negedge clk); #1;
        check_val("mstall.held", 32'(odata_read_addr), 32'd2);
        @(negedge clk); rst_n = 1'b0; #1;
        @(negedge clk); rst_n = 1'b1; stall = 1'b0; #1;
        expect_idle("mrst");
        check_val("mrst.rd", 32'(odata_read_addr), 32'd0);
        check_val("mrst.np", 32'(onextPC), 32'd0);
        check_val("mrst.addr", 32'(imem_addr), 32'd0);
        @(negedge clk); #1; expect_instr("mrst0", 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have exactly one clock and one synchronous active-low reset: clk, rst_n.
REQ-002 SHALL have no parameters; all widths fixed: 8-bit PC, 16-bit instruction word.
REQ-003 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  synchronous active-low reset, sampled on the clk rising edge.
- stall  in  1  downstream hazard hold; IFID must not load.
- branch_taken  in  1  redirect request from execute.
- branch_target  in  8  redirect PC, valid with branch_taken.
- imem_addr  out  8  instruction ROM address.
- imem_data  in  16  ROM word; synchronous read, valid 1 cycle after imem_addr.
- odata_read_addr  out  8  instruction bits [15:8], to IFID idata_read_addr.
- odata_write_addr  out  8  instruction bits [7:0], to IFID idata_write_addr.
- onextPC  out  8  fall-through PC (instruction PC + 1, mod 256), to IFID inextPC.
- ifid_en  out  1  load strobe, to IFID en.
- halted  out  1  high in HALT state.

Function
REQ-004 SHALL keep a PC register, pc, and drive imem_addr = pc combinationally.
REQ-005 SHALL keep fetch_valid (imem_data is a live fetch) and fetch_pc (address that produced the current imem_data).
REQ-006 SHALL keep a one-entry hold buffer (word, nextPC, held flag) so that a fetched word is never lost during stall.
REQ-007 SHALL implement a two-state FSM: RUN and HALT. The FSM SHALL go RUN->HALT on branch_taken with branch_target == 8'hFF. HALT SHALL exit only via reset.
REQ-008 RUN, no stall, no branch:
- pc <= pc+1 (8-bit wrap, 0xFF->0x00 with no halt);
- fetch_valid <= 1;
- ifid_en = fetch_valid.
REQ-009 Output source:
- held=1: hold buffer;
- held=0: imem_data fields, with onextPC = fetch_pc+1.
REQ-010 Stall, RUN, no branch:
- pc SHALL hold;
- ifid_en = 0;
- if fetch_valid & !held, the buffer SHALL capture the current word/nextPC and set held;
- fetch_valid SHALL hold.
REQ-011 Stall release with held=1: the buffer contents SHALL be presented with ifid_en=1 for one cycle; held SHALL clear; pc SHALL advance; the next cycle SHALL present imem_data of the re-read address (no skip, no duplicate).
REQ-012 branch_taken SHALL have priority over stall. That cycle:
- ifid_en = 0;
- pc <= branch_target;
- fetch_valid <= 0 (squash the in-flight word);
- held <= 0.
REQ-013 The first valid instruction after a redirect SHALL appear 2 cycles after the branch_taken cycle (1 bubble).
REQ-014 In HALT:
- pc frozen;
- ifid_en = 0;
- halted = 1;
- stall and branch_taken ignored.
REQ-015 Fetch latency: the word at PC P SHALL reach the outputs the cycle after pc==P (given no stall or squash).

Reset
REQ-016 On a rst_n=0 clock edge:
- pc=0x00;
- fetch_valid=0;
- held=0;
- state=RUN;
- hold buffer=0.
REQ-017 During and in the cycle after reset, ifid_en=0 and halted=0. The data outputs SHALL read 0x00 while fetch_valid=0 & held=0.
REQ-018 Reset SHALL override stall, branch_taken and HALT, in any cycle including mid-stall.
REQ-019 Instruction 0 SHALL be delivered with ifid_en=1 in the second cycle after rst_n rises.

Verification
REQ-020 Reset then free run, ROM[n]={n,~n}:
- ifid_en first high in the 2nd cycle after rst_n rises, with read=0x00, write=0xFF, nextPC=0x01;
- consecutive PCs thereafter.
REQ-021 Stall 3 cycles while instruction 5 is presented:
- ifid_en=0 for 3 cycles;
- on release, outputs 5 then 6 then 7, each with ifid_en=1, none lost or duplicated.
REQ-022 branch_taken with target 0x40 while instruction 9 is in flight:
- one bubble;
- next ifid_en=1 shows ROM[0x40] with nextPC=0x41;
- instruction 9 never delivered.
REQ-023 branch_taken and stall in the same cycle, target 0x10: redirect wins, with pc=0x10 the next cycle.
REQ-024 Sequential wrap:
- the instruction at 0xFF delivered with nextPC=0x00;
- the next delivered instruction is ROM[0x00];
- halted stays 0.
REQ-025 branch_taken to 0xFF: halted=1 and ifid_en=0 permanently; then rst_n=0 for one cycle restores RUN and pc=0x00.
